// File: rtl/input_mapper.sv
// input_mapper
//   Merges a PS/2 keyboard and two joysticks into per-player arcade controls.
//   Applies optional rotation, opposite-direction cancel, per-button autofire
//   and fixed-length coin pulses. Every output is a flop.
//
// Ports
//   clk_sys              system clock (rising edge)
//   RESET                asynchronous active-high reset
//   ps2_key[64:0]        [64] event toggle, [63:24] extra prefix bytes,
//                        [23:16]/[15:8] prefix/break, [7:0] scan code
//   joystick_0/1[15:0]   R,L,D,U, buttons, start, coin (LSB first)
//   rotate[1:0]          0 none, 1 cw, 2 ccw, 3 180
//   merge                both players see the OR of all dir/button sources
//   af_en[NUM_BTN-1:0]   per-button autofire enable
//   p1_dir/p2_dir[3:0]   {U,D,L,R}
//   p1_btn/p2_btn        action buttons
//   p1_start/p2_start    start buttons
//   coin[1:0]            [0] P1, [1] P2 coin pulses
module input_mapper #(
  parameter int                         NUM_BTN  = 3,
  parameter logic [(NUM_BTN+7)*9-1:0]   KEYMAP   = {9'h02E, 9'h006, 9'h005, 9'h029, 9'h011,
                                                    9'h014, 9'h074, 9'h06B, 9'h072, 9'h075},
  parameter logic [15:0]                COIN_LEN = 16'd50000,
  parameter logic [23:0]                AF_HALF  = 24'd400000
) (
  input  logic               clk_sys,
  input  logic               RESET,
  input  logic [64:0]        ps2_key,
  input  logic [15:0]        joystick_0,
  input  logic [15:0]        joystick_1,
  input  logic [1:0]         rotate,
  input  logic               merge,
  input  logic [NUM_BTN-1:0] af_en,
  output logic [3:0]         p1_dir,
  output logic [3:0]         p2_dir,
  output logic [NUM_BTN-1:0] p1_btn,
  output logic [NUM_BTN-1:0] p2_btn,
  output logic               p1_start,
  output logic               p2_start,
  output logic [1:0]         coin
);

  localparam int NK       = NUM_BTN + 7;
  localparam int K_START1 = NUM_BTN + 4;
  localparam int K_START2 = NUM_BTN + 5;
  localparam int K_COIN   = NUM_BTN + 6;
  localparam int J_START  = NUM_BTN + 4;
  localparam int J_COIN   = NUM_BTN + 5;

  // Upper joystick bits carry nothing for this mapping.
  logic unused_js;
  assign unused_js = &{1'b0, joystick_0[15:J_COIN+1], joystick_1[15:J_COIN+1]};

  // Rotation on {U,D,L,R}, followed by cancelling of opposing directions.
  function automatic logic [3:0] rot_dir(input logic [3:0] d, input logic [1:0] r);
    logic [3:0] o;
    case (r)
      2'd1:    o = {d[1], d[0], d[2], d[3]};
      2'd2:    o = {d[0], d[1], d[3], d[2]};
      2'd3:    o = {d[2], d[3], d[0], d[1]};
      default: o = d;
    endcase
    if (o[3] && o[2]) o[3:2] = 2'b00;
    if (o[1] && o[0]) o[1:0] = 2'b00;
    return o;
  endfunction

  logic                        armed_q, armed_d;
  logic                        tgl_q, tgl_d;
  logic [NK-1:0]               key_q, key_d;
  logic [3:0]                  p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
  logic [NUM_BTN-1:0]          p1_btn_q, p1_btn_d, p2_btn_q, p2_btn_d;
  logic                        p1_start_q, p1_start_d, p2_start_q, p2_start_d;
  logic [23:0]                 af_cnt_q, af_cnt_d;
  logic                        af_phase_q, af_phase_d;
  logic [1:0]                  coin_q, coin_d;
  logic [1:0]                  req_prev_q, req_prev_d;
  logic [1:0][15:0]            coin_cnt_q, coin_cnt_d;

  logic                        key_ev, pressed, extended;
  logic [8:0]                  code;
  logic [3:0]                  kb_dir, p1_raw_dir, p2_raw_dir;
  logic [NUM_BTN-1:0]          p1_held, p2_held, af_mask;
  logic [1:0]                  req;

  always_comb begin
    // armed_q blocks the first edge after reset from seeing a stale toggle
    // or a held coin request as a new event.
    armed_d  = 1'b1;
    tgl_d    = ps2_key[64];
    key_ev   = armed_q && (ps2_key[64] != tgl_q);
    pressed  = (ps2_key[15:8] != 8'hF0);
    extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    code     = (ps2_key[63:24] != 40'd0) ? 9'h000 : {extended, ps2_key[7:0]};

    key_d = key_q;
    if (key_ev) begin
      for (int e = 0; e < NK; e++) begin
        if ((KEYMAP[e*9 +: 9] != 9'h000) && (KEYMAP[e*9 +: 9] == code)) key_d[e] = pressed;
      end
    end

    kb_dir = {key_q[0], key_q[1], key_q[2], key_q[3]};
    if (merge) begin
      p1_raw_dir = kb_dir | joystick_0[3:0] | joystick_1[3:0];
      p2_raw_dir = p1_raw_dir;
      p1_held    = key_q[4 +: NUM_BTN] | joystick_0[4 +: NUM_BTN] | joystick_1[4 +: NUM_BTN];
      p2_held    = p1_held;
    end else begin
      p1_raw_dir = kb_dir | joystick_0[3:0];
      p2_raw_dir = joystick_1[3:0];
      p1_held    = key_q[4 +: NUM_BTN] | joystick_0[4 +: NUM_BTN];
      p2_held    = joystick_1[4 +: NUM_BTN];
    end

    p1_dir_d   = rot_dir(p1_raw_dir, rotate);
    p2_dir_d   = rot_dir(p2_raw_dir, rotate);
    p1_start_d = key_q[K_START1] | joystick_0[J_START];
    p2_start_d = key_q[K_START2] | joystick_1[J_START];

    // Shared autofire timer: idles at 0 with phase high so a fresh press
    // always starts with a full "on" half-period.
    if (|((p1_held | p2_held) & af_en)) begin
      if (af_cnt_q == AF_HALF - 24'd1) begin
        af_cnt_d   = 24'd0;
        af_phase_d = ~af_phase_q;
      end else begin
        af_cnt_d   = af_cnt_q + 24'd1;
        af_phase_d = af_phase_q;
      end
    end else begin
      af_cnt_d   = 24'd0;
      af_phase_d = 1'b1;
    end
    af_mask  = ~af_en | {NUM_BTN{af_phase_q}};
    p1_btn_d = p1_held & af_mask;
    p2_btn_d = p2_held & af_mask;

    req[0]     = joystick_0[J_COIN];
    req[1]     = key_q[K_COIN] | joystick_1[J_COIN];
    req_prev_d = req;
    coin_d     = coin_q;
    coin_cnt_d = coin_cnt_q;
    for (int n = 0; n < 2; n++) begin
      if (coin_q[n]) begin
        if (coin_cnt_q[n] == 16'd0) coin_d[n] = 1'b0;
        else                        coin_cnt_d[n] = coin_cnt_q[n] - 16'd1;
      end else if (armed_q && req[n] && !req_prev_q[n]) begin
        coin_d[n]     = 1'b1;
        coin_cnt_d[n] = COIN_LEN - 16'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      armed_q    <= 1'b0;
      tgl_q      <= 1'b0;
      key_q      <= '0;
      p1_dir_q   <= '0;
      p2_dir_q   <= '0;
      p1_btn_q   <= '0;
      p2_btn_q   <= '0;
      p1_start_q <= 1'b0;
      p2_start_q <= 1'b0;
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
      coin_q     <= '0;
      req_prev_q <= '0;
      coin_cnt_q <= '0;
    end else begin
      armed_q    <= armed_d;
      tgl_q      <= tgl_d;
      key_q      <= key_d;
      p1_dir_q   <= p1_dir_d;
      p2_dir_q   <= p2_dir_d;
      p1_btn_q   <= p1_btn_d;
      p2_btn_q   <= p2_btn_d;
      p1_start_q <= p1_start_d;
      p2_start_q <= p2_start_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
      coin_q     <= coin_d;
      req_prev_q <= req_prev_d;
      coin_cnt_q <= coin_cnt_d;
    end
  end

  assign p1_dir   = p1_dir_q;
  assign p2_dir   = p2_dir_q;
  assign p1_btn   = p1_btn_q;
  assign p2_btn   = p2_btn_q;
  assign p1_start = p1_start_q;
  assign p2_start = p2_start_q;
  assign coin     = coin_q;

endmodule

// File: doc/input_mapper.md
INPUT_MAPPER -- requirements
Module: input_mapper

Interface
REQ-001 SHALL have parameter NUM_BTN, default 3, meaning action buttons per player (legal 1..8).
REQ-002 SHALL have parameter KEYMAP, default {9'h02E,9'h006,9'h005,9'h029,9'h011,9'h014,9'h074,9'h06B,9'h072,9'h075}, meaning packed 9-bit {extended,code} per entry in this order from LSB: up, down, left, right, btn[0..NUM_BTN-1], start1, start2, coin; width (NUM_BTN+7)*9; code 9'h000 disables an entry.
REQ-003 SHALL have parameter COIN_LEN, default 16'd50000, meaning coin pulse length in clk_sys cycles (>=1).
REQ-004 SHALL have parameter AF_HALF, default 24'd400000, meaning autofire half-period in clk_sys cycles (>=1).
REQ-005 SHALL have port clk_sys  input  1  system clock; all state on its rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous active-high reset.
REQ-007 SHALL have port ps2_key  input  65  [64] event toggle, [63:24] prefix bytes, [23:16]/[15:8] prefix/break, [7:0] scan code.
REQ-008 SHALL have ports joystick_0, joystick_1  input  16 each  bits 0..3 = R,L,D,U; 4..4+NUM_BTN-1 = buttons; 4+NUM_BTN = start; 5+NUM_BTN = coin.
REQ-009 SHALL have port rotate  input  2  0 none, 1 cw, 2 ccw, 3 180.
REQ-010 SHALL have port merge  input  1  1 = both players see combined inputs.
REQ-011 SHALL have port af_en  input  NUM_BTN  per-button autofire enable.
REQ-012 SHALL have ports p1_dir, p2_dir  output  4 each  {U,D,L,R}.
REQ-013 SHALL have ports p1_btn, p2_btn  output  NUM_BTN each  action buttons.
REQ-014 SHALL have ports p1_start, p2_start  output  1 each.
REQ-015 SHALL have port coin  output  2  [0] P1, [1] P2 coin pulses.

Function
REQ-016 Key event SHALL be detected when ps2_key[64] differs from its registered previous value; key latches update on that edge.
REQ-017 pressed = (ps2_key[15:8] != 8'hF0); extended = pressed ? ps2_key[15:8]==8'hE0 : ps2_key[23:16]==8'hE0; code = {extended, ps2_key[7:0]}, forced to 0 if ps2_key[63:24] != 0.
REQ-018 Every KEYMAP entry equal to nonzero code SHALL latch pressed; duplicate entries all update; code 0 matches nothing.
REQ-019 Keyboard latches SHALL feed player 1 (start2 and coin latches feed start2 and coin[1]); joystick_0 -> P1, joystick_1 -> P2.
REQ-020 merge=1: both players SHALL receive OR of keyboard, joystick_0, joystick_1 for dir/buttons; start and coin remain per player.
REQ-021 Rotation on combined dir: rotate=1 U<-L,D<-R,L<-D,R<-U; rotate=2 U<-R,D<-L,L<-U,R<-D; rotate=3 U<-D,D<-U,L<-R,R<-L.
REQ-022 After rotation, U&D both set SHALL output both 0; L&R both set SHALL output both 0.
REQ-023 One shared free-running autofire counter SHALL toggle af_phase every AF_HALF cycles; when no af_en-enabled button held on either player, counter SHALL hold 0 and af_phase 1.
REQ-024 Button with af_en[i]=1: output = held & af_phase; af_en[i]=0: output = held.
REQ-025 Per player, rising edge of coin request (keyboard or joystick coin bit) SHALL drive coin[n] high for exactly COIN_LEN cycles; edges while active ignored; held request yields one pulse.
REQ-026 All outputs SHALL be registered; joystick change visible at first rising edge after it; keyboard event visible at second rising edge after ps2_key toggles; coin rises one cycle after request edge is sampled.

Reset
REQ-027 RESET high SHALL asynchronously clear all outputs, key latches, coin counters, coin-request history, autofire counter (af_phase=1).
REQ-028 First clk_sys edge after RESET deasserts SHALL only capture ps2_key[64], never generate a key event.
REQ-029 RESET mid coin pulse SHALL drop coin immediately; a still-held request SHALL not retrigger without release.

Verification
REQ-030 ps2_key toggle with [7:0]=8'h75,[15:8]=0 -> p1_dir=4'b1000 two edges later; toggle with [15:8]=8'hF0,[7:0]=8'h75 -> 4'b0000.
REQ-031 rotate=1, joystick_0=16'h0002 (L) -> p1_dir=4'b1000; rotate=3 -> 4'b0001; joystick_0=16'h000C (U,D) rotate=0 -> 4'b0000.
REQ-032 joystick_1 bit 8 (coin, NUM_BTN=3) held 3*COIN_LEN cycles -> coin=2'b10 for exactly COIN_LEN cycles, once.
REQ-033 AF_HALF=4, af_en=3'b001, joystick_0 bit 4 held -> p1_btn[0] high 4, low 4, repeating, starting high one cycle after press.
REQ-034 merge=1, joystick_1=16'h0010 -> p1_btn=p2_btn=3'b001; merge=0 -> p1_btn=0, p2_btn=3'b001.
REQ-035 RESET released with ps2_key[64]=1 held -> no latch change; RESET during coin pulse -> coin=0 same cycle.
